// File: rtl/arb_pkg.sv
// Shared types and constants for the SRAM two-master arbiter.
// SRAM_ARB_RESP_BYPASS_EN: when defined the RESP state is removed and the
// response is forwarded combinationally from WAIT.
package arb_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_WEN_W  = 4;

  // Owner encoding: which upstream port issued the in-flight transaction
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

`ifdef SRAM_ARB_RESP_BYPASS_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;
`endif

endpackage

// File: rtl/sram_mem_arbiter_rr_pick.sv
// Round-robin pick between fetch and data requests.
module rr_pick
  import arb_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic last_owner,
  output logic grant_c,
  output logic owner_c
);

  // On conflict the side not granted last wins; otherwise the sole requester
  always_comb begin
    grant_c = inst_req | data_req;
    owner_c = OWN_INST;
    if (inst_req && data_req) begin
      owner_c = ~last_owner;
    end else if (data_req) begin
      owner_c = OWN_DATA;
    end
  end

endmodule

// File: rtl/sram_mem_arbiter.sv
// Two-master (fetch/data) arbiter onto a single SRAM-style handshake port.
// One transaction in flight; round-robin on conflict.
// SRAM_ARB_RESP_BYPASS_EN: forward mem_data_ok/mem_rdata straight upstream
// from WAIT (2-cycle latency) instead of via the registered RESP state.
module sram_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  // fetch side
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [ARB_DATA_W-1:0] inst_rdata,
  // data side
  input  logic                  data_req,
  input  logic [ARB_WEN_W-1:0]  data_wen,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [ARB_DATA_W-1:0] data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [ARB_DATA_W-1:0] data_rdata,
  // memory side
  output logic                  mem_req,
  output logic [ARB_WEN_W-1:0]  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [ARB_DATA_W-1:0] mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [ARB_DATA_W-1:0] mem_rdata
);

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic                  mem_req_q, mem_req_d;
  logic [ARB_WEN_W-1:0]  mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [ARB_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ARB_DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [ARB_DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic grant_c, win_owner_c;
  logic inst_addr_ok_c, data_addr_ok_c;
  logic inst_data_ok_c, data_data_ok_c;

  rr_pick u_rr_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_owner (last_owner_q),
    .grant_c    (grant_c),
    .owner_c    (win_owner_c)
  );

  // Next-state, field latching and upstream handshake decode
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    mem_req_d      = mem_req_q;
    mem_wen_d      = mem_wen_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;
    inst_addr_ok_c = 1'b0;
    data_addr_ok_c = 1'b0;
    inst_data_ok_c = 1'b0;
    data_data_ok_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          state_d      = ST_ADDR;
          owner_d      = win_owner_c;
          last_owner_d = win_owner_c;
          mem_req_d    = 1'b1;
          if (win_owner_c == OWN_DATA) begin
            data_addr_ok_c = 1'b1;
            mem_wen_d      = data_wen;
            mem_addr_d     = data_addr;
            mem_wdata_d    = data_wdata;
          end else begin
            inst_addr_ok_c = 1'b1;
            mem_wen_d      = ARB_WEN_W'(0);
            mem_addr_d     = inst_addr;
            mem_wdata_d    = ARB_DATA_W'(0);
          end
        end
      end

      ST_ADDR: begin
        if (mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (mem_data_ok) begin
          if (owner_q == OWN_DATA) begin
            data_rdata_d   = mem_rdata;
            data_data_ok_c = 1'b1;
          end else begin
            inst_rdata_d   = mem_rdata;
            inst_data_ok_c = 1'b1;
          end
`ifdef SRAM_ARB_RESP_BYPASS_EN
          state_d = ST_IDLE;
`else
          state_d = ST_RESP;
`endif
        end
      end

`ifndef SRAM_ARB_RESP_BYPASS_EN
      ST_RESP: begin
        state_d = ST_IDLE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      last_owner_q <= OWN_INST;
      mem_req_q    <= 1'b0;
      mem_wen_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_req_q    <= mem_req_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // addr_ok is a same-cycle accept; held off while reset is asserted
  assign inst_addr_ok = inst_addr_ok_c & resetn;
  assign data_addr_ok = data_addr_ok_c & resetn;

  assign mem_req   = mem_req_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef SRAM_ARB_RESP_BYPASS_EN
  // Response forwarded in the WAIT cycle; registers hold it afterwards
  assign inst_data_ok = inst_data_ok_c;
  assign data_data_ok = data_data_ok_c;
  assign inst_rdata   = inst_data_ok_c ? mem_rdata : inst_rdata_q;
  assign data_rdata   = data_data_ok_c ? mem_rdata : data_rdata_q;
`else
  logic inst_data_ok_q, data_data_ok_q;

  // One-cycle registered data_ok pulse, coincident with the RESP state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
    end else begin
      inst_data_ok_q <= inst_data_ok_c;
      data_data_ok_q <= data_data_ok_c;
    end
  end

  assign inst_data_ok = inst_data_ok_q;
  assign data_data_ok = data_data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
`endif

endmodule
